message_padder: RTL and testbench

Front end of the SHA-256 mining path that feeds the `Preprocessing` message memory. It accepts a message as a byte stream, packs it big-endian into 32-bit words and applies SHA-256 padding: a 0x80 byte, zero fill, then the 64-bit bit-length. It emits one word per cycle, each tagged with a 512-bit block address and a word MSB bit index, and these drive `Preprocessing`'s `indirizzo`/`ind_width`/`message` inputs directly. On completion it reports the final block address, which becomes `indirizzo` for chunk streaming.

---
 rtl/message_padder.sv | 169 ++++++++++++++++
 tb/tb_message_padder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_padder.sv
// message_padder: packs a byte stream big-endian into 32-bit words and appends SHA-256 padding.
// Define PADDER_NONCE_TAP_EN to add the NONCE_OFFSET parameter and the nonce_addr/nonce_bit tap.
module message_padder #(
    parameter int MAX_BLOCKS = 2000
`ifdef PADDER_NONCE_TAP_EN
    ,
    parameter int NONCE_OFFSET = 76
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_word,
    output logic [15:0] out_addr,
    output logic [8:0]  out_bit,
    output logic        done,
    output logic [15:0] last_addr,
    output logic        ovf
`ifdef PADDER_NONCE_TAP_EN
    ,
    output logic [15:0] nonce_addr,
    output logic [8:0]  nonce_bit
`endif
);

    typedef enum logic [2:0] {LOAD, PAD, ZERO, LEN_HI, LEN_LO, DONE} state_t;

    // Largest message whose 0x80 byte and 64-bit length still fit in MAX_BLOCKS blocks.
    localparam logic [31:0] LIMIT = 32'(MAX_BLOCKS * 64 - 9);

    state_t      state, state_next;
    logic [31:0] byte_cnt;
    logic [23:0] pack;
    logic [3:0]  word_idx, word_nxt;
    logic [15:0] blk;
    logic        dropping;
    logic        take, drop, emit;
    logic [31:0] emit_word;

    function automatic logic [31:0] pad_word(input logic [23:0] p, input logic [1:0] k);
        logic [31:0] w;
        case (k)
            2'd0:    w = 32'h8000_0000;
            2'd1:    w = {p[23:16], 24'h80_0000};
            2'd2:    w = {p[23:8], 16'h8000};
            default: w = {p, 8'h80};
        endcase
        return w;
    endfunction

    assign in_ready = reset && (state == LOAD);
    assign take     = in_valid && in_ready;
    assign drop     = dropping || (byte_cnt == LIMIT);
    assign word_nxt = word_idx + 4'd1;

    always_ff @(posedge clock) begin
        if (!reset) state <= LOAD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_word  = 32'h0;
        case (state)
            LOAD: begin
                if (take) begin
                    if (!drop && byte_cnt[1:0] == 2'd3) begin
                        emit      = 1'b1;
                        emit_word = {pack, in_byte};
                    end
                    if (in_last) state_next = drop ? DONE : PAD;
                end
            end
            PAD: begin
                emit       = 1'b1;
                emit_word  = pad_word(pack, byte_cnt[1:0]);
                state_next = (word_nxt == 4'd14) ? LEN_HI : ZERO;
            end
            ZERO: begin
                emit = 1'b1;
                if (word_nxt == 4'd14) state_next = LEN_HI;
            end
            LEN_HI: begin
                emit       = 1'b1;
                emit_word  = {29'h0, byte_cnt[31:29]};
                state_next = LEN_LO;
            end
            LEN_LO: begin
                emit       = 1'b1;
                emit_word  = {byte_cnt[28:0], 3'b000};
                state_next = DONE;
            end
            DONE:    state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            byte_cnt  <= 32'h0;
            pack      <= 24'h0;
            word_idx  <= 4'h0;
            blk       <= 16'h0;
            dropping  <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= 32'h0;
            out_addr  <= 16'h0;
            out_bit   <= 9'h0;
            done      <= 1'b0;
            last_addr <= 16'h0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= emit;
            done      <= (state == DONE);
            if (emit) begin
                out_word <= emit_word;
                out_addr <= blk;
                out_bit  <= 9'd511 - {word_idx, 5'b00000};
                word_idx <= word_nxt;
                if (word_idx == 4'd15) blk <= blk + 16'd1;
            end
            if (take) begin
                if (drop) begin
                    dropping <= 1'b1;
                    ovf      <= 1'b1;
                end else begin
                    case (byte_cnt[1:0])
                        2'd0:    pack[23:16] <= in_byte;
                        2'd1:    pack[15:8]  <= in_byte;
                        2'd2:    pack[7:0]   <= in_byte;
                        default: ;
                    endcase
                    byte_cnt <= byte_cnt + 32'd1;
                end
            end
            // Padded messages report the LEN_LO word's block; dropped ones the block reached.
            if (state == DONE) begin
                last_addr <= dropping ? blk : out_addr;
                byte_cnt  <= 32'h0;
                pack      <= 24'h0;
                word_idx  <= 4'h0;
                blk       <= 16'h0;
                dropping  <= 1'b0;
            end
        end
    end

`ifdef PADDER_NONCE_TAP_EN
    localparam logic [29:0] NONCE_WORD = 30'(NONCE_OFFSET / 4);

    // The nonce word is either completed in LOAD or is a partial word closed by PAD.
    always_ff @(posedge clock) begin
        if (!reset) begin
            nonce_addr <= 16'h0;
            nonce_bit  <= 9'h0;
        end else if (emit && byte_cnt[31:2] == NONCE_WORD &&
                     (state == LOAD || (state == PAD && byte_cnt[1:0] != 2'd0))) begin
            nonce_addr <= blk;
            nonce_bit  <= 9'd511 - {word_idx, 5'b00000};
        end
    end
`endif

endmodule

// File: tb/tb_message_padder.sv
// Randomized bench for message_padder: each message is checked against a byte-level SHA-256
// padding model (words, block address, bit index, timing, done/last_addr, overflow).
module tb_message_padder;

    localparam int MAXB  = 2;
    localparam int LIMIT = MAXB * 64 - 9;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h0;
    logic        in_last = 1'b0;
    logic        in_ready, out_valid, done, ovf;
    logic [31:0] out_word;
    logic [15:0] out_addr, last_addr;
    logic [8:0]  out_bit;
`ifdef PADDER_NONCE_TAP_EN
    logic [15:0] nonce_addr;
    logic [8:0]  nonce_bit;
`endif

    message_padder #(.MAX_BLOCKS(MAXB)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_word(out_word), .out_addr(out_addr), .out_bit(out_bit), .done(done),
        .last_addr(last_addr), .ovf(ovf)
`ifdef PADDER_NONCE_TAP_EN
        , .nonce_addr(nonce_addr), .nonce_bit(nonce_bit)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  msg [0:255];
    int          acc_edge [0:255];
    logic [31:0] exp_word [$];

    logic [31:0] got_word [$];
    logic [15:0] got_addr [$];
    logic [8:0]  got_bit [$];
    int          got_cyc [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [15:0] done_last = 16'h0;

    always @(negedge clock) begin
        if (out_valid === 1'b1) begin
            got_word.push_back(out_word);
            got_addr.push_back(out_addr);
            got_bit.push_back(out_bit);
            got_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc  = cyc;
            done_last = last_addr;
        end
    end

    task automatic clear_mon();
        got_word.delete(); got_addr.delete(); got_bit.delete(); got_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
    endtask

    // Reference: message bytes (capped at capacity), 0x80, zeros to 56 mod 64, 64-bit bit length.
    task automatic build_expected(input int len);
        logic [7:0]  b [$];
        logic [63:0] bitlen;
        int          keep;
        exp_word.delete();
        keep = (len <= LIMIT) ? len : LIMIT;
        for (int i = 0; i < keep; i++) b.push_back(msg[i]);
        if (len <= LIMIT) begin
            b.push_back(8'h80);
            while (b.size() % 64 != 56) b.push_back(8'h00);
            bitlen = 64'(len) * 64'd8;
            for (int k = 7; k >= 0; k--) b.push_back(bitlen[8*k +: 8]);
        end
        for (int j = 0; j + 3 < b.size(); j += 4) exp_word.push_back({b[j], b[j+1], b[j+2], b[j+3]});
    endtask

    task automatic send_msg(input int len, input int gapmax, input bit with_last);
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b0; in_last = 1'b0;
            repeat ($urandom_range(gapmax, 0)) @(negedge clock);
            in_valid = 1'b1;
            in_byte  = msg[i];
            in_last  = with_last && (i == len - 1);
            acc_edge[i] = cyc + 1;
            @(negedge clock);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock); @(negedge clock);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if ({out_valid, out_word, out_addr, out_bit, done, last_addr, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b w=%h a=%h b=%h d=%b l=%h o=%b want all 0",
                     out_valid, out_word, out_addr, out_bit, done, last_addr, ovf);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        clear_mon();
        send_msg(3, 0, 1'b1);
        wait_done(100);
        checks++;
        if (got_word.size() != 16) begin errors++; $display("FAIL abc_count: got %0d want 16", got_word.size()); end
        if (got_word.size() >= 16) begin
            checks++;
            if (got_word[0] !== 32'h61626380 || got_bit[0] !== 9'd511 || got_addr[0] !== 16'd0) begin
                errors++; $display("FAIL abc_w0: got %h/%0d/%0d want 61626380/511/0", got_word[0], got_bit[0], got_addr[0]);
            end
            for (int j = 1; j < 15; j++) begin
                checks++;
                if (got_word[j] !== 32'h0) begin errors++; $display("FAIL abc_zero w%0d: got %h want 0", j, got_word[j]); end
            end
            checks++;
            if (got_word[15] !== 32'h18 || got_bit[15] !== 9'd31) begin
                errors++; $display("FAIL abc_w15: got %h/%0d want 00000018/31", got_word[15], got_bit[15]);
            end
            checks++;
            if (got_cyc[0] !== acc_edge[2] + 1) begin errors++; $display("FAIL abc_pad_time: got %0d want %0d", got_cyc[0], acc_edge[2] + 1); end
        end
        checks++;
        if (done_cnt != 1 || done_last !== 16'd0 || done_cyc != acc_edge[2] + 17) begin
            errors++; $display("FAIL abc_done: got cnt=%0d last=%0d cyc=%0d want 1/0/%0d", done_cnt, done_last, done_cyc, acc_edge[2] + 17);
        end
    endtask

    task automatic test_messages();
        int lens [$];
        int len, exp_n, nfull, last_acc, ecyc;
        lens = '{3, 55, 56, 64, 119, 1, 4, 60, 63};
        for (int r = 0; r < 10; r++) lens.push_back(int'($urandom_range(LIMIT, 1)));
        foreach (lens[t]) begin
            len = lens[t];
            fill_random();
            clear_mon();
            send_msg(len, 2, 1'b1);
            wait_done(200);
            build_expected(len);
            exp_n    = exp_word.size();
            nfull    = len / 4;
            last_acc = acc_edge[len-1];
            checks++;
            if (got_word.size() != exp_n) begin errors++; $display("FAIL msg%0d_count: got %0d want %0d", len, got_word.size(), exp_n); end
            for (int j = 0; j < exp_n && j < got_word.size(); j++) begin
                checks++;
                if ({got_word[j], got_addr[j], got_bit[j]} !== {exp_word[j], 16'(j / 16), 9'(511 - 32 * (j % 16))}) begin
                    errors++;
                    $display("FAIL msg%0d_w%0d: got %h@%0d/%0d want %h@%0d/%0d", len, j, got_word[j], got_addr[j], got_bit[j],
                             exp_word[j], j / 16, 511 - 32 * (j % 16));
                end
                ecyc = (j < nfull) ? acc_edge[4*j+3] : last_acc + (j - nfull + 1);
                checks++;
                if (got_cyc[j] != ecyc) begin errors++; $display("FAIL msg%0d_w%0d_time: got %0d want %0d", len, j, got_cyc[j], ecyc); end
            end
            checks++;
            if (done_cnt != 1 || done_last !== 16'((exp_n - 1) / 16) || done_cyc != last_acc + (exp_n - nfull) + 1) begin
                errors++;
                $display("FAIL msg%0d_done: got cnt=%0d last=%0d cyc=%0d want 1/%0d/%0d", len, done_cnt, done_last, done_cyc,
                         (exp_n - 1) / 16, last_acc + (exp_n - nfull) + 1);
            end
            checks++;
            if (ovf !== 1'b0) begin errors++; $display("FAIL msg%0d_ovf: got %b want 0", len, ovf); end
        end
    endtask

    task automatic test_overflow();
        int lens [2];
        int nbytes, exp_n;
        lens = '{200, 120};
        for (int t = 0; t < 2; t++) begin
            nbytes = lens[t];
            if (t == 1) begin
                reset = 1'b0; @(negedge clock);
                reset = 1'b1; @(negedge clock);
            end
            fill_random();
            clear_mon();
            for (int i = 0; i < nbytes; i++) begin
                in_valid = 1'b1; in_byte = msg[i]; in_last = (i == nbytes - 1);
                acc_edge[i] = cyc + 1;
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL ovf%0d_ready byte %0d: got %b want 1", nbytes, i, in_ready); end
                @(negedge clock);
                checks++;
                if (ovf !== 1'(i >= LIMIT)) begin errors++; $display("FAIL ovf%0d_flag byte %0d: got %b want %b", nbytes, i, ovf, i >= LIMIT); end
            end
            in_valid = 1'b0; in_last = 1'b0;
            wait_done(50);
            build_expected(nbytes);
            exp_n = exp_word.size();
            checks++;
            if (got_word.size() != exp_n) begin errors++; $display("FAIL ovf%0d_count: got %0d want %0d", nbytes, got_word.size(), exp_n); end
            for (int j = 0; j < exp_n && j < got_word.size(); j++) begin
                checks++;
                if (got_word[j] !== exp_word[j] || got_cyc[j] != acc_edge[4*j+3]) begin
                    errors++; $display("FAIL ovf%0d_w%0d: got %h@%0d want %h@%0d", nbytes, j, got_word[j], got_cyc[j], exp_word[j], acc_edge[4*j+3]);
                end
            end
            checks++;
            if (done_cnt != 1 || done_cyc != acc_edge[nbytes-1] + 1) begin
                errors++; $display("FAIL ovf%0d_done: got cnt=%0d cyc=%0d want 1/%0d", nbytes, done_cnt, done_cyc, acc_edge[nbytes-1] + 1);
            end
        end
        // After an overflow the next message pads normally while ovf stays set.
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        clear_mon();
        send_msg(3, 1, 1'b1);
        wait_done(100);
        checks++;
        if (got_word.size() != 16 || done_cnt != 1) begin
            errors++; $display("FAIL ovf_next_msg: got words=%0d done=%0d want 16/1", got_word.size(), done_cnt);
        end
        checks++;
        if (got_word.size() > 0 && got_word[0] !== 32'h61626380) begin
            errors++; $display("FAIL ovf_next_w0: got %h want 61626380", got_word[0]);
        end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_reset_mid();
        fill_random();
        clear_mon();
        send_msg(64, 1, 1'b1);
        wait_done(200);
        checks++;
        if (done_cnt != 1 || done_last !== 16'd1 || got_word.size() != 32) begin
            errors++; $display("FAIL len64: got done=%0d last=%0d words=%0d want 1/1/32", done_cnt, done_last, got_word.size());
        end
        checks++;
        if (got_word.size() > 16 && got_word[16] !== 32'h80000000) begin
            errors++; $display("FAIL len64_b1w0: got %h want 80000000", got_word[16]);
        end
        clear_mon();
        send_msg(30, 0, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || last_addr !== 16'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got rdy=%b v=%b last=%0d ovf=%b want 0/0/0/0", in_ready, out_valid, last_addr, ovf);
        end
        reset = 1'b1;
        repeat (20) @(negedge clock);
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL mid_reset_done: got %0d want 0", done_cnt); end
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        build_expected(3);
        clear_mon();
        send_msg(3, 0, 1'b1);
        wait_done(100);
        checks++;
        if (got_word.size() != 16 || done_cnt != 1 || done_last !== 16'd0) begin
            errors++; $display("FAIL after_reset_abc: got words=%0d done=%0d last=%0d want 16/1/0", got_word.size(), done_cnt, done_last);
        end
        for (int j = 0; j < 16 && j < got_word.size(); j++) begin
            checks++;
            if (got_word[j] !== exp_word[j] || got_addr[j] !== 16'd0) begin
                errors++; $display("FAIL after_reset_w%0d: got %h@%0d want %h@0", j, got_word[j], got_addr[j], exp_word[j]);
            end
        end
    endtask

`ifdef PADDER_NONCE_TAP_EN
    task automatic test_nonce();
        fill_random();
        clear_mon();
        send_msg(80, 1, 1'b1);
        wait_done(200);
        checks++;
        if (nonce_addr !== 16'd1 || nonce_bit !== 9'd415) begin
            errors++; $display("FAIL nonce_tap: got %0d/%0d want 1/415", nonce_addr, nonce_bit);
        end
        checks++;
        if (done_last !== 16'd1) begin errors++; $display("FAIL nonce_last: got %0d want 1", done_last); end
    endtask
`endif

    initial begin
        test_reset();
        test_abc();
        test_messages();
        test_overflow();
        test_reset_mid();
`ifdef PADDER_NONCE_TAP_EN
        test_nonce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
